// File: rtl/force_pkg.sv
// Shared types for the force/release unit: command opcodes, response codes
// and controller states.
package force_pkg;

    typedef enum logic [1:0] {
        OP_QUERY       = 2'd0,
        OP_FORCE       = 2'd1,
        OP_RELEASE     = 2'd2,
        OP_RELEASE_ALL = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK           = 2'd0,
        ST_NOOP_RELEASE = 2'd1,
        ST_EMPTY_MASK   = 2'd2
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/force_bit_cell.sv
// One bit of the overridden signal: force mask, force value, variable
// storage (variable semantics only) and the output override mux.
module force_bit_cell #(
    parameter int VAR_MODE = 0
) (
    input  logic clk,
    input  logic reset_l,
    input  logic drv_val_i,
    input  logic drv_we_i,
    input  logic set_i,
    input  logic rel_i,
    input  logic fval_i,
    output logic forced_o,
    output logic out_o
);

    logic mask_q;
    logic fval_q;
    logic var_q;
    logic base;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            mask_q <= 1'b0;
            fval_q <= 1'b0;
            var_q  <= 1'b0;
        end else begin
            if (set_i) begin
                mask_q <= 1'b1;
                fval_q <= fval_i;
            end else if (rel_i) begin
                mask_q <= 1'b0;
            end
            // Releasing keeps the forced value; a coincident driver write wins.
            if (rel_i && mask_q) begin
                var_q <= drv_we_i ? drv_val_i : fval_q;
            end else if (drv_we_i && !mask_q) begin
                var_q <= drv_val_i;
            end
        end
    end

    assign base     = (VAR_MODE != 0) ? var_q : drv_val_i;
    assign forced_o = mask_q;
    assign out_o    = mask_q ? fval_q : base;

endmodule

// File: rtl/force_release_unit.sv
// Command-driven force/release controller over a WIDTH-bit signal with
// net (VAR_MODE=0) or variable (VAR_MODE=1) release semantics.
module force_release_unit
    import force_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int VAR_MODE = 0
) (
    input  logic                         clk,
    input  logic                         reset_l,
    input  logic [WIDTH-1:0]             drv_val,
    input  logic                         drv_we,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [WIDTH-1:0]             cmd_mask,
    input  logic [WIDTH-1:0]             cmd_val,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [1:0]                   rsp_status,
    output logic [WIDTH-1:0]             out_val,
    output logic [WIDTH-1:0]             forced_mask,
    output logic [$clog2(WIDTH+1)-1:0]   force_cnt
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q;
    logic             ready_q;
    logic             rsp_valid_q;
    status_e          status_q;
    logic [CW-1:0]    cnt_q;

    op_e              op_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] val_q;

    logic             accept;
    logic             apply;
    logic [WIDTH-1:0] set_vec;
    logic [WIDTH-1:0] rel_vec;
    logic [WIDTH-1:0] forced_vec;
    logic [WIDTH-1:0] mask_d;
    status_e          status_d;

    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    assign accept = (state_q == S_IDLE) && ready_q && cmd_valid;
    assign apply  = (state_q == S_APPLY);

    always_comb begin
        set_vec  = '0;
        rel_vec  = '0;
        status_d = ST_OK;
        case (op_q)
            OP_FORCE: begin
                if (mask_q == '0) status_d = ST_EMPTY_MASK;
                else              set_vec  = mask_q;
            end
            OP_RELEASE: begin
                if (mask_q == '0) begin
                    status_d = ST_EMPTY_MASK;
                end else begin
                    rel_vec = mask_q;
                    if ((mask_q & ~forced_vec) != '0) status_d = ST_NOOP_RELEASE;
                end
            end
            OP_RELEASE_ALL: rel_vec = '1;
            default: ;
        endcase
        if (!apply) begin
            set_vec = '0;
            rel_vec = '0;
        end
        mask_d = (forced_vec & ~rel_vec) | set_vec;
    end

    // Command capture is pure data; it is only consumed in APPLY.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= op_e'(cmd_op);
            mask_q <= cmd_mask;
            val_q  <= cmd_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            status_q    <= ST_OK;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q <= 1'b0;
                        state_q <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    rsp_valid_q <= 1'b1;
                    status_q    <= status_d;
                    cnt_q       <= popcount(mask_d);
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        force_bit_cell #(
            .VAR_MODE (VAR_MODE)
        ) u_cell (
            .clk       (clk),
            .reset_l   (reset_l),
            .drv_val_i (drv_val[i]),
            .drv_we_i  (drv_we),
            .set_i     (set_vec[i]),
            .rel_i     (rel_vec[i]),
            .fval_i    (val_q[i]),
            .forced_o  (forced_vec[i]),
            .out_o     (out_val[i])
        );
    end

    assign cmd_ready   = ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_status  = status_q;
    assign forced_mask = forced_vec;
    assign force_cnt   = cnt_q;

endmodule
